// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between an operand source, the
// sequential ALU and the result consumer.
//   master : operand source / result consumer side
//   slave  : the ALU itself
interface alu_seq_if #(
  parameter int WIDTH = 8
) ();

  // request side
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;

  // result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             z;
  logic             c;
  logic             n;
  logic             v;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, f, z, c, n, v
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, f, z, c, n, v
  );

endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// One operation in flight. Single-cycle ops finish on the accepting edge;
// MUL runs a shift-add loop, one multiplier bit per cycle, for WIDTH cycles.
// A stored carry (cy) feeds ADC and is loaded from c with every result.
// Optional feature macro: ALU_SAT_EN enables ADDS (1011) and SUBS (1100);
// without it those opcodes decode as CLR.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus,
  output logic     busy
);

  localparam logic [3:0] OP_CLR = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_ASR = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_ADC = 4'b1010;
`ifdef ALU_SAT_EN
  localparam logic [3:0] OP_ADDS = 4'b1011;
  localparam logic [3:0] OP_SUBS = 4'b1100;
`endif

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW-1:0] CNT_ONE  = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r;
  logic [WIDTH-1:0]     f_r;
  logic                 z_r, c_r, n_r, v_r;
  logic                 cy_r;
  logic                 out_valid_r;
  logic                 in_ready_r;
  logic                 busy_r;
  logic [2*WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]     mplier_r;
  logic [2*WIDTH-1:0]   acc_r;
  logic [SHW-1:0]       cnt_r;

  logic [SHW-1:0]       shamt_s;
  logic [WIDTH:0]       add_s, adc_s, sub_s, shl_s, shr_s, asr_s;
  logic [WIDTH-1:0]     res_f_s;
  logic                 res_c_s, res_v_s;
  logic [2*WIDTH-1:0]   mul_acc_s;

  // Signed overflow of a sum: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sf);
    return (sa == sb) && (sf != sa);
  endfunction

  // Signed overflow of a difference: operands differ, result sign leaves a's.
  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sf);
    return (sa != sb) && (sf != sa);
  endfunction

  // Single-cycle datapath: result, carry and overflow for the presented op.
  always_comb begin
    shamt_s = bus.b[SHW-1:0];
    add_s   = {1'b0, bus.a} + {1'b0, bus.b};
    adc_s   = add_s + {{WIDTH{1'b0}}, cy_r};
    sub_s   = {1'b0, bus.a} - {1'b0, bus.b};
    // extra bit above/below the operand catches the last bit shifted out
    shl_s   = {1'b0, bus.a} << shamt_s;
    shr_s   = {bus.a, 1'b0} >> shamt_s;
    asr_s   = $signed({bus.a, 1'b0}) >>> shamt_s;
    res_f_s = {WIDTH{1'b0}};
    res_c_s = 1'b0;
    res_v_s = 1'b0;
    case (bus.op)
      OP_CLR: begin
        res_f_s = {WIDTH{1'b0}};
      end
      OP_ADD: begin
        res_f_s = add_s[WIDTH-1:0];
        res_c_s = add_s[WIDTH];
        res_v_s = add_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], add_s[WIDTH-1]);
      end
      OP_SUB: begin
        res_f_s = sub_s[WIDTH-1:0];
        res_c_s = sub_s[WIDTH];
        res_v_s = sub_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], sub_s[WIDTH-1]);
      end
      OP_OR:  res_f_s = bus.a | bus.b;
      OP_AND: res_f_s = bus.a & bus.b;
      OP_XOR: res_f_s = bus.a ^ bus.b;
      OP_SHL: begin
        res_f_s = shl_s[WIDTH-1:0];
        res_c_s = shl_s[WIDTH];
      end
      OP_SHR: begin
        res_f_s = shr_s[WIDTH:1];
        res_c_s = shr_s[0];
      end
      OP_ASR: begin
        res_f_s = asr_s[WIDTH:1];
        res_c_s = asr_s[0];
      end
      OP_ADC: begin
        res_f_s = adc_s[WIDTH-1:0];
        res_c_s = adc_s[WIDTH];
        res_v_s = add_ovf(bus.a[WIDTH-1], bus.b[WIDTH-1], adc_s[WIDTH-1]);
      end
`ifdef ALU_SAT_EN
      OP_ADDS: begin
        if (add_s[WIDTH]) begin
          res_f_s = {WIDTH{1'b1}};
          res_c_s = 1'b1;
        end else begin
          res_f_s = add_s[WIDTH-1:0];
          res_c_s = 1'b0;
        end
      end
      OP_SUBS: begin
        if (sub_s[WIDTH]) begin
          res_f_s = {WIDTH{1'b0}};
          res_c_s = 1'b1;
        end else begin
          res_f_s = sub_s[WIDTH-1:0];
          res_c_s = 1'b0;
        end
      end
`endif
      default: begin
        // MUL is handled by the iterative path; illegal opcodes act as CLR
        res_f_s = {WIDTH{1'b0}};
      end
    endcase
  end

  // One shift-add step: add the shifted multiplicand when the current bit is set.
  always_comb begin
    mul_acc_s = acc_r;
    if (mplier_r[0]) begin
      mul_acc_s = acc_r + mcand_r;
    end else begin
      mul_acc_s = acc_r;
    end
  end

  // Control FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      f_r         <= {WIDTH{1'b0}};
      z_r         <= 1'b1;
      c_r         <= 1'b0;
      n_r         <= 1'b0;
      v_r         <= 1'b0;
      cy_r        <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
      mcand_r     <= {(2*WIDTH){1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      cnt_r       <= {SHW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            if (bus.op == OP_MUL) begin
              mcand_r  <= {{WIDTH{1'b0}}, bus.a};
              mplier_r <= bus.b;
              acc_r    <= {(2*WIDTH){1'b0}};
              cnt_r    <= {SHW{1'b0}};
              state_r  <= ST_MUL;
            end else begin
              f_r         <= res_f_s;
              z_r         <= (res_f_s == {WIDTH{1'b0}});
              n_r         <= res_f_s[WIDTH-1];
              c_r         <= res_c_s;
              v_r         <= res_v_s;
              cy_r        <= res_c_s;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end
          end
        end
        ST_MUL: begin
          acc_r    <= mul_acc_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CNT_ONE;
          // last bit: publish the product straight from this step's sum
          if (cnt_r == CNT_LAST) begin
            f_r         <= mul_acc_s[WIDTH-1:0];
            z_r         <= (mul_acc_s[WIDTH-1:0] == {WIDTH{1'b0}});
            n_r         <= mul_acc_s[WIDTH-1];
            c_r         <= |mul_acc_s[2*WIDTH-1:WIDTH];
            v_r         <= 1'b0;
            cy_r        <= |mul_acc_s[2*WIDTH-1:WIDTH];
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.f         = f_r;
  assign bus.z         = z_r;
  assign bus.c         = c_r;
  assign bus.n         = n_r;
  assign bus.v         = v_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=8) against
// an integer-arithmetic reference model.
module tb_alu_seq;

  logic clk;
  logic rst;
  logic busy;
  int   n_checks;
  int   n_errors;
  logic cy_m;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {v, c, f} from plain integer arithmetic on the operand values.
  function automatic logic [9:0] model(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic cy);
    int ua, ub, sa, sb, s, r, sr;
    logic [7:0] f;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    s  = ub % 8;
    f = 8'h00; c = 1'b0; v = 1'b0;
    case (op)
      4'd1: begin
        r = ua + ub; f = 8'(r); c = (r > 255);
        sr = sa + sb; v = (sr > 127) || (sr < -128);
      end
      4'd2: begin
        r = ua - ub; f = 8'(r); c = (ua < ub);
        sr = sa - sb; v = (sr > 127) || (sr < -128);
      end
      4'd3: f = a | b;
      4'd4: f = a & b;
      4'd5: f = a ^ b;
      4'd6: begin
        f = 8'(ua * (1 << s));
        c = (s == 0) ? 1'b0 : 1'((ua / (1 << (8 - s))) % 2);
      end
      4'd7: begin
        f = 8'(ua / (1 << s));
        c = (s == 0) ? 1'b0 : 1'((ua / (1 << (s - 1))) % 2);
      end
      4'd8: begin
        f = 8'(sa >>> s);
        c = (s == 0) ? 1'b0 : 1'((ua / (1 << (s - 1))) % 2);
      end
      4'd9: begin
        r = ua * ub; f = 8'(r); c = (r > 255);
      end
      4'd10: begin
        r = ua + ub + int'(cy); f = 8'(r); c = (r > 255);
        sr = sa + sb + int'(cy); v = (sr > 127) || (sr < -128);
      end
`ifdef ALU_SAT_EN
      4'd11: begin
        r = ua + ub;
        if (r > 255) begin f = 8'hFF; c = 1'b1; end else begin f = 8'(r); end
      end
      4'd12: begin
        if (ua < ub) begin f = 8'h00; c = 1'b1; end else begin f = 8'(ua - ub); end
      end
`endif
      default: begin f = 8'h00; c = 1'b0; end
    endcase
    return {v, c, f};
  endfunction

  // Present one op while idle, wait for the result and check it (result is left held).
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [9:0] e;
    int lat;
    e = model(op, a, b, cy_m);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency op%0d", op), lat, (op == 4'd9) ? 9 : 1);
    check($sformatf("f op%0d a%0h b%0h", op, a, b), bus.f, e[7:0]);
    check($sformatf("c op%0d a%0h b%0h", op, a, b), bus.c, e[8]);
    check($sformatf("v op%0d a%0h b%0h", op, a, b), bus.v, e[9]);
    check($sformatf("z op%0d", op), bus.z, (e[7:0] == 8'h00));
    check($sformatf("n op%0d", op), bus.n, e[7]);
    check("in_ready in DONE", bus.in_ready, 1'b0);
    check("busy in DONE", busy, 1'b1);
    cy_m = e[8];
  endtask

  // Take the held result after dly stall cycles and check the return to idle.
  task automatic consume(input int dly);
    repeat (dly) @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("out_valid after take", bus.out_valid, 1'b0);
    check("in_ready after take", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] hf;
    logic [3:0] hflags;
    n_checks = 0; n_errors = 0; cy_m = 1'b0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 4'h0; bus.a = 8'h00; bus.b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst f", bus.f, 8'h00);
    check("rst z", bus.z, 1'b1);
    check("rst c", bus.c, 1'b0);
    check("rst n", bus.n, 1'b0);
    check("rst v", bus.v, 1'b0);
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst in_ready", bus.in_ready, 1'b1);
    check("rst busy", busy, 1'b0);
    @(negedge clk); rst = 1'b0;

    // directed vectors with literal expectations
    run_op(4'd1, 8'hF9, 8'h07);
    check("tp add f", bus.f, 8'h00); check("tp add c", bus.c, 1'b1);
    check("tp add z", bus.z, 1'b1);  check("tp add v", bus.v, 1'b0);
    consume(0);
    run_op(4'd10, 8'h01, 8'h01);
    check("tp adc f", bus.f, 8'h03); check("tp adc c", bus.c, 1'b0);
    consume(1);
    run_op(4'd2, 8'h00, 8'h01);
    check("tp sub f", bus.f, 8'hFF); check("tp sub c", bus.c, 1'b1);
    check("tp sub n", bus.n, 1'b1);
    consume(0);
    run_op(4'd2, 8'h80, 8'h01);
    check("tp sub2 f", bus.f, 8'h7F); check("tp sub2 v", bus.v, 1'b1);
    consume(0);
    run_op(4'd9, 8'h0F, 8'h11);
    check("tp mul f", bus.f, 8'hFF); check("tp mul c", bus.c, 1'b0);
    consume(0);
    run_op(4'd9, 8'h10, 8'h10);
    check("tp mul2 f", bus.f, 8'h00); check("tp mul2 c", bus.c, 1'b1);
    check("tp mul2 z", bus.z, 1'b1);
    consume(0);
    run_op(4'd6, 8'h81, 8'h01);
    check("tp shl f", bus.f, 8'h02); check("tp shl c", bus.c, 1'b1);
    consume(0);
    run_op(4'd8, 8'h90, 8'h03);
    check("tp asr f", bus.f, 8'hF2); check("tp asr c", bus.c, 1'b0);
    consume(0);
    run_op(4'd7, 8'h01, 8'h00);
    check("tp shr f", bus.f, 8'h01); check("tp shr c", bus.c, 1'b0);
    consume(0);
    run_op(4'd13, 8'hFF, 8'hFF);
    check("illegal f", bus.f, 8'h00);
    consume(0);

    // backpressure: result held, new request ignored
    run_op(4'd3, 8'h5A, 8'h24);
    hf = bus.f; hflags = {bus.z, bus.c, bus.n, bus.v};
    check("bp f", hf, 8'h7E);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd1; bus.a = 8'h01; bus.b = 8'h01;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp f stable", bus.f, hf);
      check("bp flags stable", {bus.z, bus.c, bus.n, bus.v}, hflags);
      check("bp out_valid", bus.out_valid, 1'b1);
      check("bp in_ready", bus.in_ready, 1'b0);
    end
    @(negedge clk); bus.in_valid = 1'b0;
    consume(0);
    @(posedge clk); #1;
    check("bp no stray result", bus.out_valid, 1'b0);
    check("bp idle busy", busy, 1'b0);

    // reset part-way through a multiply, with cy previously set
    run_op(4'd1, 8'hFF, 8'h01);
    consume(0);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd9; bus.a = 8'h33; bus.b = 8'h55;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("mulrst out_valid", bus.out_valid, 1'b0);
    check("mulrst z", bus.z, 1'b1);
    check("mulrst f", bus.f, 8'h00);
    check("mulrst busy", busy, 1'b0);
    check("mulrst in_ready", bus.in_ready, 1'b1);
    @(negedge clk); rst = 1'b0; cy_m = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("mulrst no result", bus.out_valid, 1'b0);
    run_op(4'd10, 8'h02, 8'h03);
    check("post rst adc f", bus.f, 8'h05);
    consume(0);
    run_op(4'd1, 8'h02, 8'h03);
    check("post rst add f", bus.f, 8'h05);
    consume(0);

    // randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      run_op(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      consume(int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
